// File: rtl/multicycle_control_pkg.sv
// Shared constants, state codes and control-word layout for the multi-cycle MIPS controller.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Codes 12..15 are unreachable and decode to "all outputs 0, go to FETCH".
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_supported_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational output decoder: current state plus memory handshake and opcode -> control word.
module multicycle_ctrl_outdec
    import multicycle_control_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_mem_ready,
    input  logic [5:0] i_op,
    output ctrl_t      o_ctrl
);

    // Memory handshake: a request (memRead/memWrite) stays asserted with a stable
    // address select until the cycle mem_ready=1; that cycle completes the access,
    // so every side effect tied to the access is qualified by i_mem_ready.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALU_OP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b  = SRCB_IMM_SH2;
                o_ctrl.alu_op     = ALU_OP_ADD;
                o_ctrl.illegal_op = !is_supported_op(i_op);
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMRD: begin
                o_ctrl.ior_d    = 1'b1;
                o_ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.ior_d      = 1'b1;
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.instr_done = i_mem_ready;
            end
            S_RTYPE_EX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_RTYPE_WB: begin
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_BEQ: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_B;
                o_ctrl.alu_op        = ALU_OP_SUB;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.instr_done    = 1'b1;
            end
            S_ADDI_EX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            S_ADDI_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_source  = PCSRC_JUMP;
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: state register, next-state logic and reset gating of outputs.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] alu_op,
    output logic [1:0] pcSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t r_state;
    state_t w_next;
    logic   w_mem_ready;
    ctrl_t  w_ctrl;
    ctrl_t  w_ctrl_gated;

    assign w_mem_ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = w_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPE_EX;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_ADDI:      w_next = S_ADDI_EX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    w_next = w_mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWR:    w_next = w_mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPE_EX: w_next = S_RTYPE_WB;
            S_RTYPE_WB: w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_ADDI_EX:  w_next = S_ADDI_WB;
            S_ADDI_WB:  w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    multicycle_ctrl_outdec u_outdec (
        .i_state     (r_state),
        .i_mem_ready (w_mem_ready),
        .i_op        (op),
        .o_ctrl      (w_ctrl)
    );

    // Outputs are forced low combinationally so an aborted access stops the same instant.
    assign w_ctrl_gated = rst_n ? w_ctrl : '0;

    assign pcWrite     = w_ctrl_gated.pc_write;
    assign pcWriteCond = w_ctrl_gated.pc_write_cond;
    assign iorD        = w_ctrl_gated.ior_d;
    assign memRead     = w_ctrl_gated.mem_read;
    assign memWrite    = w_ctrl_gated.mem_write;
    assign irWrite     = w_ctrl_gated.ir_write;
    assign memToReg    = w_ctrl_gated.mem_to_reg;
    assign regDst      = w_ctrl_gated.reg_dst;
    assign regWrite    = w_ctrl_gated.reg_write;
    assign aluSrcA     = w_ctrl_gated.alu_src_a;
    assign aluSrcB     = w_ctrl_gated.alu_src_b;
    assign alu_op      = w_ctrl_gated.alu_op;
    assign pcSource    = w_ctrl_gated.pc_source;
    assign instr_done  = w_ctrl_gated.instr_done;
    assign illegal_op  = w_ctrl_gated.illegal_op;
    assign state_o     = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class state by state.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA, instr_done, illegal_op;
    logic [1:0] aluSrcB, alu_op, pcSource;
    logic [3:0] state_o;
    logic [17:0] w_out;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .mem_ready   (mem_ready),
        .pcWrite     (pcWrite),
        .pcWriteCond (pcWriteCond),
        .iorD        (iorD),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .irWrite     (irWrite),
        .memToReg    (memToReg),
        .regDst      (regDst),
        .regWrite    (regWrite),
        .aluSrcA     (aluSrcA),
        .aluSrcB     (aluSrcB),
        .alu_op      (alu_op),
        .pcSource    (pcSource),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .state_o     (state_o)
    );

    assign w_out = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                    regDst, regWrite, aluSrcA, aluSrcB, alu_op, pcSource, instr_done, illegal_op};

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: pcWrite pcWriteCond iorD memRead memWrite irWrite memToReg regDst
    //              regWrite aluSrcA aluSrcB alu_op pcSource instr_done illegal_op
    localparam logic [17:0] E_ZERO      = 18'b0;
    localparam logic [17:0] E_FETCH_RDY = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_FETCH_STL = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_DECODE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_DECODE_IL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b1};
    localparam logic [17:0] E_MEMADR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_MEMRD     = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_MEMWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [17:0] E_MEMWR_STL = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_MEMWR_RDY = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [17:0] E_RTYPE_EX  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_RTYPE_WB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [17:0] E_BEQ       = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0};
    localparam logic [17:0] E_ADDI_EX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_ADDI_WB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [17:0] E_JUMP      = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0};

    // Scoreboard check
    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    // Settle inputs, check state and full control word, then advance one clock.
    task automatic cyc(input string tag, input logic [3:0] es, input logic [17:0] ev);
        #1;
        chk({tag, "_state"}, {14'd0, state_o}, {14'd0, es});
        chk({tag, "_out"}, w_out, ev);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        op        = 6'b000000;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {14'd0, state_o}, 18'd0);
        chk("reset_out", w_out, E_ZERO);
        rst_n = 1'b1;

        // lw, no stall: 5 cycles
        op = 6'b100011;
        cyc("lw_fetch", 4'd0, E_FETCH_RDY);
        cyc("lw_decode", 4'd1, E_DECODE);
        cyc("lw_memadr", 4'd2, E_MEMADR);
        cyc("lw_memrd", 4'd3, E_MEMRD);
        cyc("lw_memwb", 4'd4, E_MEMWB);

        // sw with three stall cycles in MEMWR
        op = 6'b101011;
        cyc("sw_fetch", 4'd0, E_FETCH_RDY);
        cyc("sw_decode", 4'd1, E_DECODE);
        cyc("sw_memadr", 4'd2, E_MEMADR);
        mem_ready = 1'b0;
        cyc("sw_stall0", 4'd5, E_MEMWR_STL);
        cyc("sw_stall1", 4'd5, E_MEMWR_STL);
        cyc("sw_stall2", 4'd5, E_MEMWR_STL);
        mem_ready = 1'b1;
        cyc("sw_exit", 4'd5, E_MEMWR_RDY);

        // R-type then beq
        op = 6'b000000;
        cyc("r_fetch", 4'd0, E_FETCH_RDY);
        cyc("r_decode", 4'd1, E_DECODE);
        op = 6'b100011;
        cyc("r_ex", 4'd6, E_RTYPE_EX);
        cyc("r_wb", 4'd7, E_RTYPE_WB);
        op = 6'b000100;
        cyc("beq_fetch", 4'd0, E_FETCH_RDY);
        cyc("beq_decode", 4'd1, E_DECODE);
        cyc("beq_exec", 4'd8, E_BEQ);

        // illegal opcode, followed by a fetch stall
        op = 6'b111111;
        cyc("ill_fetch", 4'd0, E_FETCH_RDY);
        cyc("ill_decode", 4'd1, E_DECODE_IL);
        mem_ready = 1'b0;
        cyc("fetch_stall", 4'd0, E_FETCH_STL);
        mem_ready = 1'b1;

        // j, then addi with op changing mid-instruction
        op = 6'b000010;
        cyc("j_fetch", 4'd0, E_FETCH_RDY);
        cyc("j_decode", 4'd1, E_DECODE);
        cyc("j_jump", 4'd11, E_JUMP);
        op = 6'b001000;
        cyc("addi_fetch", 4'd0, E_FETCH_RDY);
        cyc("addi_decode", 4'd1, E_DECODE);
        op = 6'b101011;
        cyc("addi_ex", 4'd9, E_ADDI_EX);
        cyc("addi_wb", 4'd10, E_ADDI_WB);

        // Reset asserted mid-MEMWR stall
        op = 6'b101011;
        cyc("rst_fetch", 4'd0, E_FETCH_RDY);
        cyc("rst_decode", 4'd1, E_DECODE);
        cyc("rst_memadr", 4'd2, E_MEMADR);
        mem_ready = 1'b0;
        #1;
        chk("rst_memwr_state", {14'd0, state_o}, 18'd5);
        chk("rst_memwr_out", w_out, E_MEMWR_STL);
        rst_n = 1'b0;
        #1;
        chk("rst_async_state", {14'd0, state_o}, 18'd0);
        chk("rst_async_out", w_out, E_ZERO);
        @(posedge clk);
        #1;
        chk("rst_held_out", w_out, E_ZERO);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        cyc("rst_release", 4'd0, E_FETCH_RDY);
        cyc("rst_decode2", 4'd1, E_DECODE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
